// File: rtl/kmeans_k3n2_ctrl_pkg.sv
// Shared types and width helpers for the k=3, 2-D k-means iteration controller.
package kmeans_k3n2_ctrl_pkg;

    localparam int unsigned DW_DEF = 8;
    localparam int unsigned AW_DEF = 8;
    localparam int unsigned N_CENT = 6;   // 3 centroids x 2 dimensions

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_STREAM,
        ST_DRAIN,
        ST_DIVIDE,
        ST_UPDATE,
        ST_DONE
    } state_t;

    // Sum accumulators must hold 2**AW points of DW bits each.
    function automatic int unsigned sum_w(input int unsigned dw, input int unsigned aw);
        return dw + aw;
    endfunction

    // Counters must reach 2**AW inclusive.
    function automatic int unsigned cnt_w(input int unsigned aw);
        return aw + 1;
    endfunction

endpackage

// File: rtl/kmeans_k3n2_ctrl_if.sv
// Controller <-> RAM / distance pipeline / host signal bundle.
interface kmeans_k3n2_ctrl_if #(
    parameter int unsigned DW = kmeans_k3n2_ctrl_pkg::DW_DEF,
    parameter int unsigned AW = kmeans_k3n2_ctrl_pkg::AW_DEF
);
    logic          start;
    logic [AW-1:0] ram_rd_address;
    logic [1:0]    sel_centroid;
    logic [DW-1:0] pipe_d0;
    logic [DW-1:0] pipe_d1;
    logic [DW-1:0] k0d0;
    logic [DW-1:0] k0d1;
    logic [DW-1:0] k1d0;
    logic [DW-1:0] k1d1;
    logic [DW-1:0] k2d0;
    logic [DW-1:0] k2d1;
    logic          busy;
    logic          done;
    logic          converged;
    logic [4:0]    iteration;

    // Controller side
    modport master (
        input  start, sel_centroid, pipe_d0, pipe_d1,
        output ram_rd_address, k0d0, k0d1, k1d0, k1d1, k2d0, k2d1,
        output busy, done, converged, iteration
    );

    // Host / datapath side
    modport slave (
        output start, sel_centroid, pipe_d0, pipe_d1,
        input  ram_rd_address, k0d0, k0d1, k1d0, k1d1, k2d0, k2d1,
        input  busy, done, converged, iteration
    );
endinterface

// File: rtl/kmeans_seq_divider.sv
// Restoring unsigned divider, one quotient bit per clock; done pulses SUM_W+1 clocks after start.
module kmeans_seq_divider #(
    parameter int unsigned SUM_W = 16,
    parameter int unsigned CNT_W = 9,
    parameter int unsigned Q_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_start,
    input  logic [SUM_W-1:0] i_dividend,
    input  logic [CNT_W-1:0] i_divisor,
    output logic             o_done,
    output logic [Q_W-1:0]   o_quotient
);
    localparam int unsigned REM_W  = CNT_W + 1;
    localparam int unsigned STEP_W = $clog2(SUM_W + 1);

    logic [CNT_W-1:0]  r_rem;
    logic [SUM_W-1:0]  r_quo;
    logic [CNT_W-1:0]  r_div;
    logic [STEP_W-1:0] r_step;
    logic              r_run;
    logic              r_done;

    logic [REM_W-1:0]  w_shift;
    logic              w_ge;
    logic [REM_W-1:0]  w_diff;

    // Trial subtraction of the divisor from the shifted partial remainder.
    always_comb begin
        w_shift = {r_rem, r_quo[SUM_W-1]};
        w_ge    = (w_shift >= {1'b0, r_div});
        w_diff  = w_shift - {1'b0, r_div};
    end

    // Iteration registers; remainder always stays below the divisor so CNT_W bits suffice.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rem  <= '0;
            r_quo  <= '0;
            r_div  <= '0;
            r_step <= '0;
            r_run  <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (i_start) begin
                r_rem  <= '0;
                r_quo  <= i_dividend;
                r_div  <= i_divisor;
                r_step <= STEP_W'(SUM_W);
                r_run  <= 1'b1;
            end else if (r_run) begin
                r_rem  <= w_ge ? CNT_W'(w_diff) : CNT_W'(w_shift);
                r_quo  <= {r_quo[SUM_W-2:0], w_ge};
                r_step <= r_step - STEP_W'(1);
                if (r_step == STEP_W'(1)) begin
                    r_run  <= 1'b0;
                    r_done <= 1'b1;
                end
            end
        end
    end

    assign o_done     = r_done;
    assign o_quotient = r_quo[Q_W-1:0];

endmodule

// File: rtl/kmeans_k3n2_ctrl.sv
// k-means (k=3, 2-D) iteration controller: address sweep, accumulation, division, convergence.
module kmeans_k3n2_ctrl
    import kmeans_k3n2_ctrl_pkg::*;
#(
    parameter int unsigned input_data_width         = DW_DEF,
    parameter int unsigned input_data_qty_bit_width = AW_DEF,
    parameter int unsigned input_data_qty           = 256,
    parameter int unsigned pipeline_latency         = 5,
    parameter int unsigned max_iterations           = 16,
    parameter int unsigned k0_d0_initial            = 0,
    parameter int unsigned k0_d1_initial            = 0,
    parameter int unsigned k1_d0_initial            = 1,
    parameter int unsigned k1_d1_initial            = 1,
    parameter int unsigned k2_d0_initial            = 2,
    parameter int unsigned k2_d1_initial            = 2
) (
    input  logic               clk,
    input  logic               rst,
    kmeans_k3n2_ctrl_if.master bus
);
    localparam int unsigned DW    = input_data_width;
    localparam int unsigned AW    = input_data_qty_bit_width;
    localparam int unsigned LAT   = pipeline_latency;
    localparam int unsigned SUM_W = sum_w(DW, AW);
    localparam int unsigned CNT_W = cnt_w(AW);

    function automatic logic [DW-1:0] init_val(input int unsigned idx);
        case (idx)
            0:       return DW'(k0_d0_initial);
            1:       return DW'(k0_d1_initial);
            2:       return DW'(k1_d0_initial);
            3:       return DW'(k1_d1_initial);
            4:       return DW'(k2_d0_initial);
            default: return DW'(k2_d1_initial);
        endcase
    endfunction

    state_t           r_state;
    state_t           w_next;
    logic [AW-1:0]    r_addr;
    logic [LAT-1:0]   r_vld;
    logic [SUM_W-1:0] r_sum [N_CENT];
    logic [CNT_W-1:0] r_cnt [3];
    logic [DW-1:0]    r_cent [N_CENT];
    logic [DW-1:0]    r_new [N_CENT];
    logic [2:0]       r_div_idx;
    logic             r_div_run;
    logic             r_busy;
    logic             r_done;
    logic             r_conv;
    logic [4:0]       r_iter;

    logic             w_last_addr;
    logic             w_vld_empty;
    logic             w_acc;
    logic [2:0]       w_acc_idx;
    logic [SUM_W-1:0] w_dividend;
    logic [CNT_W-1:0] w_divisor;
    logic             w_cnt_zero;
    logic             w_div_start;
    logic             w_div_done;
    logic [DW-1:0]    w_quot;
    logic             w_div_step;
    logic             w_moved;
    logic             w_iter_last;

    // Status decode for the sweep, accumulation and divide sequencing.
    always_comb begin
        w_last_addr = (r_addr == AW'(input_data_qty - 1));
        w_vld_empty = (r_vld == '0);
        w_acc       = r_vld[LAT-1] && (bus.sel_centroid != 2'd3);
        w_acc_idx   = {bus.sel_centroid, 1'b0};
        w_dividend  = r_sum[r_div_idx];
        w_divisor   = r_cnt[r_div_idx[2:1]];
        w_cnt_zero  = (w_divisor == '0);
        w_iter_last = (5'(r_iter + 5'd1) == 5'(max_iterations));
        w_moved     = 1'b0;
        for (int i = 0; i < N_CENT; i++) begin
            if (r_new[i] != r_cent[i]) begin
                w_moved = 1'b1;
            end
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic and divider launch.
    always_comb begin
        w_next      = r_state;
        w_div_start = 1'b0;
        w_div_step  = 1'b0;
        case (r_state)
            ST_IDLE:   if (bus.start) w_next = ST_CLEAR;
            ST_CLEAR:  w_next = ST_STREAM;
            ST_STREAM: if (w_last_addr) w_next = ST_DRAIN;
            ST_DRAIN:  if (w_vld_empty) w_next = ST_DIVIDE;
            ST_DIVIDE: begin
                w_div_start = !r_div_run && !w_cnt_zero;
                w_div_step  = r_div_run ? w_div_done : w_cnt_zero;
                if (w_div_step && (r_div_idx == 3'd5)) w_next = ST_UPDATE;
            end
            ST_UPDATE: w_next = (!w_moved || w_iter_last) ? ST_DONE : ST_CLEAR;
            ST_DONE:   w_next = ST_IDLE;
            default:   w_next = ST_IDLE;
        endcase
    end

    // Datapath registers: address, valid pipe, accumulators, centroids and status.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_addr    <= '0;
            r_vld     <= '0;
            r_div_idx <= '0;
            r_div_run <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_conv    <= 1'b0;
            r_iter    <= '0;
            for (int i = 0; i < N_CENT; i++) begin
                r_sum[i]  <= '0;
                r_cent[i] <= init_val(i);
                r_new[i]  <= init_val(i);
            end
            for (int i = 0; i < 3; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            r_vld  <= LAT'({r_vld, (r_state == ST_STREAM)});
            r_busy <= (w_next != ST_IDLE);
            r_done <= (w_next == ST_DONE);
            case (r_state)
                ST_IDLE: begin
                    if (bus.start) begin
                        r_iter <= '0;
                        r_conv <= 1'b0;
                        for (int i = 0; i < N_CENT; i++) begin
                            r_cent[i] <= init_val(i);
                        end
                    end
                end
                ST_CLEAR: begin
                    for (int i = 0; i < N_CENT; i++) begin
                        r_sum[i] <= '0;
                    end
                    for (int i = 0; i < 3; i++) begin
                        r_cnt[i] <= '0;
                    end
                end
                ST_STREAM: begin
                    r_addr <= w_last_addr ? '0 : r_addr + AW'(1);
                end
                ST_DRAIN: begin
                    r_div_idx <= '0;
                    r_div_run <= 1'b0;
                end
                ST_DIVIDE: begin
                    if (w_div_start) begin
                        r_div_run <= 1'b1;
                    end
                    if (w_div_step) begin
                        r_new[r_div_idx] <= r_div_run ? w_quot : r_cent[r_div_idx];
                        r_div_run        <= 1'b0;
                        r_div_idx        <= r_div_idx + 3'd1;
                    end
                end
                ST_UPDATE: begin
                    r_iter <= r_iter + 5'd1;
                    for (int i = 0; i < N_CENT; i++) begin
                        r_cent[i] <= r_new[i];
                    end
                    if (w_next == ST_DONE) begin
                        r_conv <= !w_moved;
                    end
                end
                default: ;
            endcase
            if (w_acc) begin
                r_sum[w_acc_idx]        <= r_sum[w_acc_idx] + SUM_W'(bus.pipe_d0);
                r_sum[w_acc_idx + 3'd1] <= r_sum[w_acc_idx + 3'd1] + SUM_W'(bus.pipe_d1);
                r_cnt[bus.sel_centroid] <= r_cnt[bus.sel_centroid] + CNT_W'(1);
            end
        end
    end

    kmeans_seq_divider #(
        .SUM_W (SUM_W),
        .CNT_W (CNT_W),
        .Q_W   (DW)
    ) u_div (
        .clk        (clk),
        .rst        (rst),
        .i_start    (w_div_start),
        .i_dividend (w_dividend),
        .i_divisor  (w_divisor),
        .o_done     (w_div_done),
        .o_quotient (w_quot)
    );

    assign bus.ram_rd_address = r_addr;
    assign bus.k0d0           = r_cent[0];
    assign bus.k0d1           = r_cent[1];
    assign bus.k1d0           = r_cent[2];
    assign bus.k1d1           = r_cent[3];
    assign bus.k2d0           = r_cent[4];
    assign bus.k2d1           = r_cent[5];
    assign bus.busy           = r_busy;
    assign bus.done           = r_done;
    assign bus.converged      = r_conv;
    assign bus.iteration      = r_iter;

endmodule

// File: tb/tb_kmeans_k3n2_ctrl.sv
// Bench for kmeans_k3n2_ctrl: emulated RAM + 5-stage distance pipeline, vector table, scoreboard.
module tb_kmeans_k3n2_ctrl;
    localparam int LAT = 5;
    localparam int QTY = 4;

    typedef struct packed {
        logic           which;
        logic           nearest;
        logic [3:0][7:0] d0;
        logic [3:0][7:0] d1;
        logic [3:0][1:0] sel;
        logic [5:0][7:0] exp_c;
        logic           exp_conv;
        logic [4:0]     exp_iter;
    } vec_t;

    typedef struct packed {
        logic [5:0][7:0] c;
        logic           conv;
        logic [4:0]     iter;
    } exp_t;

    typedef struct packed {
        logic [5:0][7:0] c;
        logic           conv;
        logic [4:0]     iter;
        logic           busy;
        logic           done;
        logic [7:0]     addr;
    } obs_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    kmeans_k3n2_ctrl_if #(.DW(8), .AW(8)) bus0 ();
    kmeans_k3n2_ctrl_if #(.DW(8), .AW(8)) bus1 ();

    kmeans_k3n2_ctrl #(.input_data_qty(QTY), .pipeline_latency(LAT), .max_iterations(16))
        dut0 (.clk(clk), .rst(rst), .bus(bus0));
    kmeans_k3n2_ctrl #(.input_data_qty(QTY), .pipeline_latency(LAT), .max_iterations(1))
        dut1 (.clk(clk), .rst(rst), .bus(bus1));

    logic [7:0] ram_d0 [256];
    logic [7:0] ram_d1 [256];
    logic [1:0] ram_sel [256];
    logic       nearest_mode;
    logic [7:0] aq0 [LAT];
    logic [7:0] aq1 [LAT];

    int total = 0;
    int bad   = 0;
    exp_t sb_q[$];
    vec_t tab[9];
    logic [5:0][7:0] init_c;

    // Nearest centroid by squared Euclidean distance, ties to the lower index.
    function automatic logic [1:0] nearest(input logic [7:0] p0, input logic [7:0] p1,
                                           input logic [5:0][7:0] c);
        int best;
        int d;
        int a;
        int b;
        logic [1:0] bi;
        best = 0;
        bi   = 2'd0;
        for (int k = 0; k < 3; k++) begin
            a = int'(p0) - int'(c[2*k]);
            b = int'(p1) - int'(c[2*k+1]);
            d = a*a + b*b;
            if (k == 0 || d < best) begin
                best = d;
                bi   = 2'(k);
            end
        end
        return bi;
    endfunction

    // Address delay lines model the pipeline latency.
    always @(posedge clk) begin
        aq0[0] <= bus0.ram_rd_address;
        aq1[0] <= bus1.ram_rd_address;
        for (int i = 1; i < LAT; i++) begin
            aq0[i] <= aq0[i-1];
            aq1[i] <= aq1[i-1];
        end
    end

    // Pipeline outputs for both DUTs, derived from the delayed address.
    always_comb begin
        bus0.pipe_d0 = ram_d0[aq0[LAT-1]];
        bus0.pipe_d1 = ram_d1[aq0[LAT-1]];
        bus0.sel_centroid = nearest_mode ?
            nearest(ram_d0[aq0[LAT-1]], ram_d1[aq0[LAT-1]],
                    {bus0.k2d1, bus0.k2d0, bus0.k1d1, bus0.k1d0, bus0.k0d1, bus0.k0d0}) :
            ram_sel[aq0[LAT-1]];
        bus1.pipe_d0 = ram_d0[aq1[LAT-1]];
        bus1.pipe_d1 = ram_d1[aq1[LAT-1]];
        bus1.sel_centroid = nearest_mode ?
            nearest(ram_d0[aq1[LAT-1]], ram_d1[aq1[LAT-1]],
                    {bus1.k2d1, bus1.k2d0, bus1.k1d1, bus1.k1d0, bus1.k0d1, bus1.k0d0}) :
            ram_sel[aq1[LAT-1]];
    end

    function automatic obs_t snap(input logic which);
        obs_t o;
        if (!which) begin
            o.c    = {bus0.k2d1, bus0.k2d0, bus0.k1d1, bus0.k1d0, bus0.k0d1, bus0.k0d0};
            o.conv = bus0.converged; o.iter = bus0.iteration;
            o.busy = bus0.busy; o.done = bus0.done; o.addr = bus0.ram_rd_address;
        end else begin
            o.c    = {bus1.k2d1, bus1.k2d0, bus1.k1d1, bus1.k1d0, bus1.k0d1, bus1.k0d0};
            o.conv = bus1.converged; o.iter = bus1.iteration;
            o.busy = bus1.busy; o.done = bus1.done; o.addr = bus1.ram_rd_address;
        end
        return o;
    endfunction

    function automatic vec_t mkv(input int w, input int nr,
                                 input int a0, input int a1, input int b0, input int b1,
                                 input int c0, input int c1, input int e0, input int e1,
                                 input int s0, input int s1, input int s2, input int s3,
                                 input int x0, input int x1, input int x2, input int x3,
                                 input int x4, input int x5, input int cv, input int it);
        vec_t v;
        v.which = 1'(w); v.nearest = 1'(nr);
        v.d0[0] = 8'(a0); v.d1[0] = 8'(a1); v.d0[1] = 8'(b0); v.d1[1] = 8'(b1);
        v.d0[2] = 8'(c0); v.d1[2] = 8'(c1); v.d0[3] = 8'(e0); v.d1[3] = 8'(e1);
        v.sel[0] = 2'(s0); v.sel[1] = 2'(s1); v.sel[2] = 2'(s2); v.sel[3] = 2'(s3);
        v.exp_c[0] = 8'(x0); v.exp_c[1] = 8'(x1); v.exp_c[2] = 8'(x2);
        v.exp_c[3] = 8'(x3); v.exp_c[4] = 8'(x4); v.exp_c[5] = 8'(x5);
        v.exp_conv = 1'(cv); v.exp_iter = 5'(it);
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic set_start(input logic which, input logic v);
        if (!which) bus0.start = v;
        else        bus1.start = v;
    endtask

    task automatic load(input vec_t v);
        for (int i = 0; i < QTY; i++) begin
            ram_d0[i]  = v.d0[i];
            ram_d1[i]  = v.d1[i];
            ram_sel[i] = v.sel[i];
        end
        nearest_mode = v.nearest;
    endtask

    // One full run: expectation queued at start, compared when done pulses.
    task automatic run_vec(input vec_t v, input string name, input bit spurious);
        exp_t e;
        obs_t o;
        bit   seen;
        int   extra;
        load(v);
        e.c = v.exp_c; e.conv = v.exp_conv; e.iter = v.exp_iter;
        sb_q.push_back(e);
        @(negedge clk); set_start(v.which, 1'b1);
        @(negedge clk); set_start(v.which, 1'b0);
        o = snap(v.which);
        chk({name, " busy_after_start"}, 64'(o.busy), 64'(1));
        seen = 1'b0;
        for (int n = 0; n < 4000 && !seen; n++) begin
            @(negedge clk);
            o = snap(v.which);
            if (n <= 4) chk({name, " addr_seq"}, 64'(o.addr), (n == 4) ? 64'(0) : 64'(n));
            if (n == 2) chk({name, " cent_stable"}, 64'(o.c), 64'(init_c));
            set_start(v.which, spurious && (n == 3 || n == 40));
            if (o.done) seen = 1'b1;
        end
        set_start(v.which, 1'b0);
        chk({name, " done_seen"}, 64'(seen), 64'(1));
        e = sb_q.pop_front();
        if (seen) begin
            chk({name, " centroids"}, 64'(o.c), 64'(e.c));
            chk({name, " converged"}, 64'(o.conv), 64'(e.conv));
            chk({name, " iteration"}, 64'(o.iter), 64'(e.iter));
            extra = 0;
            for (int n = 0; n < 60; n++) begin
                @(negedge clk);
                o = snap(v.which);
                if (n == 0) chk({name, " busy_after_done"}, 64'(o.busy), 64'(0));
                if (o.done) extra++;
            end
            chk({name, " extra_done"}, 64'(extra), 64'(0));
            chk({name, " iter_hold"}, 64'(o.iter), 64'(e.iter));
            chk({name, " cent_hold"}, 64'(o.c), 64'(e.c));
        end
    endtask

    initial begin
        obs_t o;
        bit   hit;
        init_c = {8'd2, 8'd2, 8'd1, 8'd1, 8'd0, 8'd0};
        for (int i = 0; i < 256; i++) begin
            ram_d0[i] = 8'd0; ram_d1[i] = 8'd0; ram_sel[i] = 2'd3;
        end
        nearest_mode = 1'b0;
        bus0.start = 1'b0;
        bus1.start = 1'b0;

        //            w nr  p0        p1        p2         p3        sels      expected centroids        cv it
        tab[0] = mkv(0, 1, 10,10,    10,10,    10,10,     10,10,    0,0,0,0,  0,0,  1,1,  10,10,     1, 2);
        tab[1] = mkv(0, 0,  3,4,      4,4,    100,100,     7,9,     1,1,3,3,  0,0,  3,4,   2,2,      1, 2);
        tab[2] = mkv(0, 0,  9,200,   10,201,  255,0,       0,255,   0,0,2,2,  9,200, 1,1, 127,127,   1, 2);
        tab[3] = mkv(0, 0, 255,255, 255,255,  255,255,   254,0,     0,0,0,0, 254,191, 1,1, 2,2,      1, 2);
        tab[4] = mkv(0, 0, 50,60,    70,80,    90,100,   110,120,   3,3,3,3,  0,0,  1,1,   2,2,      1, 1);
        tab[5] = mkv(0, 1,  0,0,      1,1,      2,2,       2,2,     0,0,0,0,  0,0,  1,1,   2,2,      1, 1);
        tab[6] = mkv(0, 1,  0,0,      0,2,      9,9,       9,7,     0,0,0,0,  0,0,  0,2,   9,8,      1, 2);
        tab[7] = mkv(1, 0,  5,5,      5,5,      5,5,       5,5,     0,0,0,0,  5,5,  1,1,   2,2,      0, 1);
        tab[8] = mkv(1, 1,  0,0,      1,1,      2,2,       2,2,     0,0,0,0,  0,0,  1,1,   2,2,      1, 1);

        // Reset state
        rst = 1'b0;
        repeat (3) @(negedge clk);
        o = snap(1'b0);
        chk("reset cent", 64'(o.c), 64'(init_c));
        chk("reset busy", 64'(o.busy), 64'(0));
        chk("reset done", 64'(o.done), 64'(0));
        chk("reset conv", 64'(o.conv), 64'(0));
        chk("reset iter", 64'(o.iter), 64'(0));
        chk("reset addr", 64'(o.addr), 64'(0));
        o = snap(1'b1);
        chk("reset cent dut1", 64'(o.c), 64'(init_c));
        rst = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 9; i++) begin
            run_vec(tab[i], $sformatf("vec%0d", i), 1'b0);
        end

        // Start pulses during STREAM and DIVIDE must be ignored.
        run_vec(tab[0], "spurious_start", 1'b1);

        // Asynchronous reset in the middle of the second iteration's sweep.
        load(tab[0]);
        @(negedge clk); bus0.start = 1'b1;
        @(negedge clk); bus0.start = 1'b0;
        hit = 1'b0;
        for (int n = 0; n < 2000 && !hit; n++) begin
            @(negedge clk);
            if (bus0.iteration == 5'd1) hit = 1'b1;
        end
        chk("midrun reach iter1", 64'(hit), 64'(1));
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        o = snap(1'b0);
        chk("midrun rst cent", 64'(o.c), 64'(init_c));
        chk("midrun rst iter", 64'(o.iter), 64'(0));
        chk("midrun rst busy", 64'(o.busy), 64'(0));
        chk("midrun rst addr", 64'(o.addr), 64'(0));
        chk("midrun rst conv", 64'(o.conv), 64'(0));
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        run_vec(tab[0], "after_reset", 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
